// File: rtl/lps_pkg.sv
// ---------------------------------------------------------------------------
// lps_pkg
// Shared definitions for the line_point_sink slice: default grid geometry,
// the {x,y} point struct, the sink FSM state encoding and the absolute
// difference helper used by the optional step-adjacency checker.
// ---------------------------------------------------------------------------
package lps_pkg;

  localparam int LPS_COORD_W = 4;
  localparam int LPS_N       = 1 << LPS_COORD_W;

  // Width used by abs_diff; callers zero-extend their coordinates into it so
  // the helper is usable for any COORD_W up to 16.
  localparam int LPS_DIFF_W  = 16;

  typedef struct packed {
    logic [LPS_COORD_W-1:0] x;
    logic [LPS_COORD_W-1:0] y;
  } point_t;

  typedef enum logic [1:0] {
    CLR,
    ACCEPT,
    DONE
  } lps_state_e;

  function automatic logic [LPS_DIFF_W-1:0] abs_diff(
    input logic [LPS_DIFF_W-1:0] a,
    input logic [LPS_DIFF_W-1:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/line_point_sink_if.sv
// ---------------------------------------------------------------------------
// line_point_sink_if
// Point stream handshake between the line generator (master) and the sink
// (slave).
//   pt_valid  master->slave  point present on pt_data
//   pt_ready  slave->master  sink accepts a point this cycle
//   pt_data   master->slave  {x,y}, x in the upper COORD_W bits
//   pt_last   master->slave  marks the final point of a line
// ---------------------------------------------------------------------------
interface line_point_sink_if #(
  parameter int COORD_W = lps_pkg::LPS_COORD_W
) ();

  logic                 pt_valid;
  logic                 pt_ready;
  logic [2*COORD_W-1:0] pt_data;
  logic                 pt_last;

  modport master (
    output pt_valid,
    output pt_data,
    output pt_last,
    input  pt_ready
  );

  modport slave (
    input  pt_valid,
    input  pt_data,
    input  pt_last,
    output pt_ready
  );

endinterface

// File: rtl/lps_adj_check.sv
// ---------------------------------------------------------------------------
// lps_adj_check
// Step-adjacency checker for the point stream. Raises err for one cycle when
// fire is high and new_pt is not exactly one Chebyshev step away from
// prev_pt (a repeated point counts as an error too).
//   prev_pt  in   previous accepted point {x,y}
//   new_pt   in   point being accepted now {x,y}
//   fire     in   a transfer that has a predecessor is happening
//   err      out  combinational error pulse
// Only built when LPS_ADJ_CHECK_EN is defined, so a default build carries no
// checker logic at all.
// ---------------------------------------------------------------------------
`ifdef LPS_ADJ_CHECK_EN
module lps_adj_check
  import lps_pkg::*;
#(
  parameter int COORD_W = LPS_COORD_W
) (
  input  logic [2*COORD_W-1:0] prev_pt,
  input  logic [2*COORD_W-1:0] new_pt,
  input  logic                 fire,
  output logic                 err
);

  logic [LPS_DIFF_W-1:0] dx;
  logic [LPS_DIFF_W-1:0] dy;
  logic                  adjacent;

  // Differences are taken on plain unsigned coordinates, so 0 and N-1 are
  // far apart rather than neighbours.
  assign dx = abs_diff(LPS_DIFF_W'(prev_pt[2*COORD_W-1:COORD_W]),
                       LPS_DIFF_W'(new_pt[2*COORD_W-1:COORD_W]));
  assign dy = abs_diff(LPS_DIFF_W'(prev_pt[COORD_W-1:0]),
                       LPS_DIFF_W'(new_pt[COORD_W-1:0]));

  // max(|dx|,|dy|) == 1 means both axes move by at most one and not both
  // stand still.
  assign adjacent = (dx <= LPS_DIFF_W'(1)) && (dy <= LPS_DIFF_W'(1)) &&
                    ((dx | dy) != '0);

  assign err = fire && !adjacent;

endmodule
`endif

// File: rtl/line_point_sink.sv
// ---------------------------------------------------------------------------
// line_point_sink
// Consumer end of the line generator coordinate stream. Each accepted {x,y}
// point sets one pixel in a 2^COORD_W square bitmap held in flops; rows are
// read back through a registered port. First/last point, a saturating point
// count and a frame-done flag summarise the drawn line.
// Optional feature: define LPS_ADJ_CHECK_EN to build the step-adjacency
// checker that drives the sticky adj_err flag; otherwise adj_err is 0.
//   clk         clock, all state on posedge
//   rst         synchronous active-high reset, wins over every input
//   pt          point stream handshake (slave side)
//   clear       start a new frame: sweep the bitmap, zero statistics
//   rd_row      row (y) to read
//   rd_data     registered row rd_row, bit [x] = pixel (x,rd_row)
//   first_pt    first point accepted since clear/reset
//   last_pt     most recent point accepted
//   pt_count    points accepted since clear/reset, saturating
//   frame_done  set the cycle after the pt_last point is accepted
//   adj_err     sticky non-adjacent step flag (LPS_ADJ_CHECK_EN only)
// ---------------------------------------------------------------------------
module line_point_sink
  import lps_pkg::*;
#(
  parameter int  COORD_W = LPS_COORD_W,
  parameter int  CNT_W   = 9,
  localparam int N       = 1 << COORD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  line_point_sink_if.slave     pt,
  input  logic                 clear,
  input  logic [COORD_W-1:0]   rd_row,
  output logic [N-1:0]         rd_data,
  output logic [2*COORD_W-1:0] first_pt,
  output logic [2*COORD_W-1:0] last_pt,
  output logic [CNT_W-1:0]     pt_count,
  output logic                 frame_done,
  output logic                 adj_err
);

  lps_state_e         state;
  lps_state_e         state_next;
  logic [N-1:0]       bitmap [N];
  logic [COORD_W-1:0] clr_row;
  logic [COORD_W-1:0] pt_x;
  logic [COORD_W-1:0] pt_y;
  logic               xfer;

  assign pt_x = pt.pt_data[2*COORD_W-1:COORD_W];
  assign pt_y = pt.pt_data[COORD_W-1:0];

  // Ready depends only on state and clear so the producer never sees a
  // combinational path from its own valid back to ready.
  assign pt.pt_ready = (state == ACCEPT) && !clear;
  assign xfer        = pt.pt_valid && pt.pt_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCEPT;
    end else begin
      state <= state_next;
    end
  end

  // clear from any state restarts the row sweep; the sweep leaves CLR once
  // the last row (all-ones pointer) has been written.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = CLR;
    end else begin
      case (state)
        CLR:     if (&clr_row) state_next = ACCEPT;
        ACCEPT:  if (xfer && pt.pt_last) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = ACCEPT;
      endcase
    end
  end

  // The read uses the pre-edge bitmap, so a pixel written in the same cycle
  // shows up on the following read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        bitmap[r] <= '0;
      end
      rd_data <= '0;
    end else begin
      rd_data <= bitmap[rd_row];
      if (state == CLR) begin
        bitmap[clr_row] <= '0;
      end
      if (xfer) begin
        bitmap[pt_y][pt_x] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_row    <= '0;
      first_pt   <= '0;
      last_pt    <= '0;
      pt_count   <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      clr_row    <= '0;
      first_pt   <= '0;
      last_pt    <= '0;
      pt_count   <= '0;
      frame_done <= 1'b0;
    end else begin
      if (state == CLR) begin
        clr_row <= clr_row + 1'b1;
      end
      if (xfer) begin
        last_pt <= pt.pt_data;
        if (pt_count == '0) begin
          first_pt <= pt.pt_data;
        end
        if (pt_count != '1) begin
          pt_count <= pt_count + 1'b1;
        end
        if (pt.pt_last) begin
          frame_done <= 1'b1;
        end
      end
    end
  end

`ifdef LPS_ADJ_CHECK_EN
  logic adj_fire;
  logic adj_pulse;
  logic adj_err_q;

  // The very first point of a frame has no predecessor to compare with.
  assign adj_fire = xfer && (pt_count != '0);

  lps_adj_check #(
    .COORD_W (COORD_W)
  ) u_adj_check (
    .prev_pt (last_pt),
    .new_pt  (pt.pt_data),
    .fire    (adj_fire),
    .err     (adj_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      adj_err_q <= 1'b0;
    end else if (adj_pulse) begin
      adj_err_q <= 1'b1;
    end
  end

  assign adj_err = adj_err_q;
`else
  assign adj_err = 1'b0;
`endif

endmodule

// File: tb/tb_line_point_sink.sv
// ---------------------------------------------------------------------------
// tb_line_point_sink
// Directed bench for line_point_sink (16x16 grid, 9-bit count). Inputs are
// driven 1 ns after each rising edge and outputs are sampled at the same
// point, so every check sees the state produced by the preceding edge.
// Expected adj_err follows LPS_ADJ_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_line_point_sink;
  import lps_pkg::*;

`ifdef LPS_ADJ_CHECK_EN
  localparam logic ADJ_ON = 1'b1;
`else
  localparam logic ADJ_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        clear;
  logic [3:0]  rd_row;
  logic [15:0] rd_data;
  logic [7:0]  first_pt;
  logic [7:0]  last_pt;
  logic [8:0]  pt_count;
  logic        frame_done;
  logic        adj_err;

  int vectors_applied = 0;
  int miscompares     = 0;

  line_point_sink_if #(.COORD_W(4)) pt_if ();

  line_point_sink #(
    .COORD_W (4),
    .CNT_W   (9)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pt         (pt_if.slave),
    .clear      (clear),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .first_pt   (first_pt),
    .last_pt    (last_pt),
    .pt_count   (pt_count),
    .frame_done (frame_done),
    .adj_err    (adj_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic v,
                               input logic [7:0] d, input logic l,
                               input logic [3:0] row);
    rst             = r;
    clear           = c;
    pt_if.pt_valid  = v;
    pt_if.pt_data   = d;
    pt_if.pt_last   = l;
    rd_row          = row;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors_applied++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Fixed-length directed run; this only trips if the sequence itself stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  diag_pts [4];
    logic [15:0] row_exp  [5];
    diag_pts = '{8'h00, 8'h11, 8'h22, 8'h33};
    row_exp  = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0000};

    // Reset
    applyStimulus(1, 0, 0, 8'h00, 0, 4'd0);
    tick();
    checkOutput("rst_count", 32'(pt_count), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_first", 32'(first_pt), 32'h00);
    checkOutput("rst_last", 32'(last_pt), 32'h00);
    checkOutput("rst_rd_data", 32'(rd_data), 32'h0000);
    checkOutput("rst_adj_err", 32'(adj_err), 32'd0);
    checkOutput("rst_ready", 32'(pt_if.pt_ready), 32'd1);

    // Diagonal (0,0)..(3,3), last on (3,3)
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, diag_pts[i], (i == 3), 4'd0);
      tick();
    end
    applyStimulus(0, 0, 0, 8'h00, 0, 4'd0);
    checkOutput("diag_frame_done", 32'(frame_done), 32'd1);
    checkOutput("diag_count", 32'(pt_count), 32'd4);
    checkOutput("diag_first", 32'(first_pt), 32'h00);
    checkOutput("diag_last", 32'(last_pt), 32'h33);
    checkOutput("diag_done_ready", 32'(pt_if.pt_ready), 32'd0);
    checkOutput("diag_adj_err", 32'(adj_err), 32'd0);
    for (int r = 0; r < 5; r++) begin
      applyStimulus(0, 0, 0, 8'h00, 0, 4'(r));
      tick();
      checkOutput($sformatf("diag_row%0d", r), 32'(rd_data), 32'(row_exp[r]));
    end

    // Valid held in DONE: nothing is taken
    applyStimulus(0, 0, 1, 8'h44, 1, 4'd0);
    repeat (3) tick();
    checkOutput("done_hold_count", 32'(pt_count), 32'd4);
    checkOutput("done_hold_last", 32'(last_pt), 32'h33);
    checkOutput("done_hold_ready", 32'(pt_if.pt_ready), 32'd0);

    // Clear with valid still held through the sweep
    applyStimulus(0, 1, 1, 8'h44, 0, 4'd0);
    #1;
    checkOutput("clear_cycle_ready", 32'(pt_if.pt_ready), 32'd0);
    tick();
    applyStimulus(0, 0, 1, 8'h44, 0, 4'd0);
    checkOutput("clear_count", 32'(pt_count), 32'd0);
    checkOutput("clear_frame_done", 32'(frame_done), 32'd0);
    checkOutput("clear_first", 32'(first_pt), 32'h00);
    checkOutput("clear_last", 32'(last_pt), 32'h00);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("clr_ready_%0d", i), 32'(pt_if.pt_ready), 32'd0);
      if (i == 1) checkOutput("clr_row0_stale", 32'(rd_data), 32'h0001);
      if (i == 2) checkOutput("clr_row0_wiped", 32'(rd_data), 32'h0000);
      tick();
    end
    checkOutput("clr_end_ready", 32'(pt_if.pt_ready), 32'd1);
    checkOutput("clr_end_count", 32'(pt_count), 32'd0);
    applyStimulus(0, 0, 0, 8'h00, 0, 4'd0);
    for (int r = 0; r < 16; r++) begin
      applyStimulus(0, 0, 0, 8'h00, 0, 4'(r));
      tick();
      checkOutput($sformatf("clr_row%0d", r), 32'(rd_data), 32'h0000);
    end

    // Valid toggling in ACCEPT: (1,0),(2,0),(3,0),(4,0) on even cycles
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) applyStimulus(0, 0, 1, 8'((i / 2 + 1) << 4), 0, 4'd0);
      else            applyStimulus(0, 0, 0, 8'hFF, 0, 4'd0);
      tick();
    end
    applyStimulus(0, 0, 0, 8'h00, 0, 4'd0);
    checkOutput("toggle_count", 32'(pt_count), 32'd4);
    checkOutput("toggle_first", 32'(first_pt), 32'h10);
    checkOutput("toggle_last", 32'(last_pt), 32'h40);
    checkOutput("toggle_adj_err", 32'(adj_err), 32'd0);
    checkOutput("toggle_frame_done", 32'(frame_done), 32'd0);
    tick();
    checkOutput("toggle_row0", 32'(rd_data), 32'h001E);
    applyStimulus(0, 0, 0, 8'h00, 0, 4'd15);
    tick();
    checkOutput("toggle_row15", 32'(rd_data), 32'h0000);

    // New frame
    applyStimulus(0, 1, 0, 8'h00, 0, 4'd7);
    tick();
    applyStimulus(0, 0, 0, 8'h00, 0, 4'd7);
    repeat (16) tick();

    // (2,2)->(3,3) adjacent, (5,3) jump, then (5,7) with rd_row=7
    applyStimulus(0, 0, 1, 8'h22, 0, 4'd7);
    tick();
    applyStimulus(0, 0, 1, 8'h33, 0, 4'd7);
    tick();
    checkOutput("adj_ok", 32'(adj_err), 32'd0);
    applyStimulus(0, 0, 1, 8'h53, 0, 4'd7);
    tick();
    checkOutput("adj_jump", 32'(adj_err), 32'(ADJ_ON));
    applyStimulus(0, 0, 1, 8'h57, 1, 4'd7);
    tick();
    applyStimulus(0, 0, 0, 8'h00, 0, 4'd7);
    checkOutput("hazard_same_cycle", 32'(rd_data), 32'h0000);
    checkOutput("hazard_frame_done", 32'(frame_done), 32'd1);
    tick();
    checkOutput("hazard_next_read", 32'(rd_data), 32'h0020);
    checkOutput("hazard_count", 32'(pt_count), 32'd4);
    checkOutput("hazard_first", 32'(first_pt), 32'h22);
    checkOutput("hazard_last", 32'(last_pt), 32'h57);
    repeat (2) tick();
    checkOutput("adj_held_done", 32'(adj_err), 32'(ADJ_ON));
    checkOutput("adj_done_ready", 32'(pt_if.pt_ready), 32'd0);
    applyStimulus(0, 1, 0, 8'h00, 0, 4'd0);
    tick();
    applyStimulus(0, 0, 0, 8'h00, 0, 4'd0);
    checkOutput("adj_cleared", 32'(adj_err), 32'd0);
    checkOutput("adj_clear_frame_done", 32'(frame_done), 32'd0);
    repeat (16) tick();

    // Reset mid-stream with a point offered
    applyStimulus(0, 0, 1, 8'h00, 0, 4'd0);
    tick();
    applyStimulus(0, 0, 1, 8'h01, 0, 4'd0);
    tick();
    applyStimulus(0, 0, 1, 8'h02, 0, 4'd0);
    tick();
    checkOutput("mid_count", 32'(pt_count), 32'd3);
    applyStimulus(1, 0, 1, 8'h03, 0, 4'd0);
    tick();
    applyStimulus(0, 0, 0, 8'h00, 0, 4'd3);
    checkOutput("midrst_count", 32'(pt_count), 32'd0);
    checkOutput("midrst_first", 32'(first_pt), 32'h00);
    checkOutput("midrst_last", 32'(last_pt), 32'h00);
    checkOutput("midrst_ready", 32'(pt_if.pt_ready), 32'd1);
    checkOutput("midrst_rd_data", 32'(rd_data), 32'h0000);
    tick();
    checkOutput("midrst_row3", 32'(rd_data), 32'h0000);
    applyStimulus(0, 0, 0, 8'h00, 0, 4'd0);
    tick();
    checkOutput("midrst_row0", 32'(rd_data), 32'h0000);

    // Saturation: 515 repeated (0,0) points, then a last point
    for (int i = 0; i < 515; i++) begin
      applyStimulus(0, 0, 1, 8'h00, 0, 4'd0);
      tick();
    end
    applyStimulus(0, 0, 0, 8'h00, 0, 4'd0);
    checkOutput("sat_count", 32'(pt_count), 32'd511);
    checkOutput("sat_adj_err", 32'(adj_err), 32'(ADJ_ON));
    applyStimulus(0, 0, 1, 8'h11, 1, 4'd1);
    tick();
    applyStimulus(0, 0, 0, 8'h00, 0, 4'd1);
    checkOutput("sat_last_count", 32'(pt_count), 32'd511);
    checkOutput("sat_last_frame_done", 32'(frame_done), 32'd1);
    checkOutput("sat_last_pt", 32'(last_pt), 32'h11);
    checkOutput("sat_first_pt", 32'(first_pt), 32'h00);
    checkOutput("sat_last_ready", 32'(pt_if.pt_ready), 32'd0);
    tick();
    checkOutput("sat_row1", 32'(rd_data), 32'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
